// File: rtl/rv32i_pkg.sv
// Shared RV32I opcode constants and the source/destination decode used by operand fetch.
package rv32i_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic use_rs1;
    logic use_rs2;
    logic rd_we;
  } src_dec_t;

  function automatic src_dec_t decode_src(input logic [6:0] opcode, input logic [4:0] rd);
    src_dec_t d;
    d.use_rs1 = opcode inside {OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JALR};
    d.use_rs2 = opcode inside {OPC_OP, OPC_STORE, OPC_BRANCH};
    d.rd_we   = (opcode inside {OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_LUI, OPC_AUIPC,
                                OPC_JAL, OPC_JALR}) && (rd != 5'd0);
    return d;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy bit per architectural register: set on issue, cleared by write-back or by
// flushing the issued instruction. A set in the same cycle as a clear wins.
module reg_scoreboard #(
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            set_en,
  input  logic [4:0]      set_idx,
  input  logic            wb_en,
  input  logic [4:0]      wb_idx,
  input  logic            flush_en,
  input  logic [4:0]      flush_idx,
  output logic [NREG-1:0] busy
);

  logic [NREG-1:0] busy_next;

  always_comb begin
    busy_next = busy;
    if (wb_en)    busy_next[wb_idx]    = 1'b0;
    if (flush_en) busy_next[flush_idx] = 1'b0;
    if (set_en)   busy_next[set_idx]   = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy <= '0;
    else      busy <= busy_next;
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads the register file, bypasses write-back data, stalls on
// RAW/WAW hazards via the scoreboard and holds one issued instruction for execute.
module operand_fetch
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [31:0]     pc_in,
  output logic [4:0]      rs1_enc,
  output logic [4:0]      rs2_enc,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            wb_valid,
  input  logic [4:0]      wb_enc,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_pc,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_op1,
  output logic [XLEN-1:0] out_op2,
  output logic [4:0]      out_rd,
  output logic            out_rd_we
);

  src_dec_t        dec;
  logic [4:0]      rd_enc;
  logic            bypass1, bypass2, wb_hits_rd;
  logic            hazard, accept;
  logic [XLEN-1:0] op1_val, op2_val;
  logic [NREG-1:0] busy;

  assign rs1_enc = instr[19:15];
  assign rs2_enc = instr[24:20];
  assign rd_enc  = instr[11:7];
  assign dec     = decode_src(instr[6:0], rd_enc);

  assign bypass1    = wb_valid && (wb_enc == rs1_enc) && (rs1_enc != 5'd0);
  assign bypass2    = wb_valid && (wb_enc == rs2_enc) && (rs2_enc != 5'd0);
  assign wb_hits_rd = wb_valid && (wb_enc == rd_enc);

  always_comb begin
    op1_val = rs1;
    if (rs1_enc == 5'd0) op1_val = '0;
    else if (bypass1)    op1_val = wb_data;
    op2_val = rs2;
    if (rs2_enc == 5'd0) op2_val = '0;
    else if (bypass2)    op2_val = wb_data;
  end

  // A write-back landing this cycle resolves the hazard it would otherwise cause.
  assign hazard = (dec.use_rs1 && busy[rs1_enc] && !bypass1) ||
                  (dec.use_rs2 && busy[rs2_enc] && !bypass2) ||
                  (dec.rd_we   && busy[rd_enc]  && !wb_hits_rd);

  assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  reg_scoreboard #(.NREG(NREG)) u_sb (
    .clk       (clk),
    .rst       (rst),
    .set_en    (accept && dec.rd_we),
    .set_idx   (rd_enc),
    .wb_en     (wb_valid),
    .wb_idx    (wb_enc),
    .flush_en  (flush && out_valid && out_rd_we),
    .flush_idx (out_rd),
    .busy      (busy)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_instr <= '0;
      out_op1   <= '0;
      out_op2   <= '0;
      out_rd    <= '0;
      out_rd_we <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_pc    <= pc_in;
      out_instr <= instr;
      out_op1   <= op1_val;
      out_op2   <= op2_val;
      out_rd    <= rd_enc;
      out_rd_we <= dec.rd_we;
    end else if (flush || out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: reset, RAW stall with bypass, backpressure, x0,
// WAW with simultaneous write-back, flush and asynchronous reset mid-transfer.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] instr, pc_in;
  logic [4:0]  rs1_enc, rs2_enc;
  logic [31:0] rs1, rs2;
  logic        wb_valid;
  logic [4:0]  wb_enc;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_instr, out_op1, out_op2;
  logic [4:0]  out_rd;
  logic        out_rd_we;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  operand_fetch #(.XLEN(32), .NREG(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc_in(pc_in), .rs1_enc(rs1_enc), .rs2_enc(rs2_enc),
    .rs1(rs1), .rs2(rs2), .wb_valid(wb_valid), .wb_enc(wb_enc), .wb_data(wb_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_op1(out_op1), .out_op2(out_op2),
    .out_rd(out_rd), .out_rd_we(out_rd_we)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] i_type(input logic [4:0] rd, input logic [4:0] s1,
                                         input logic [11:0] imm);
    return {imm, s1, 3'b000, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] r_type(input logic [4:0] rd, input logic [4:0] s1,
                                         input logic [4:0] s2);
    return {7'b0, s2, s1, 3'b000, rd, 7'b0110011};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; instr = '0; pc_in = '0; rs1 = '0; rs2 = '0;
    wb_valid = 1'b0; wb_enc = '0; wb_data = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_pc", out_pc, 0);
    check_eq("rst_out_op1", out_op1, 0);
    check_eq("rst_busy", dut.u_sb.busy, 0);
    rst = 1'b1;
    #1;
    check_eq("rst_in_ready", in_ready, 1);

    // RAW: addi x5,x0,7 then add x6,x5,x5
    instr = i_type(5'd5, 5'd0, 12'd7); pc_in = 32'h100;
    rs1 = 32'hdead_beef; rs2 = 32'h1234; in_valid = 1'b1;
    #1;
    check_eq("raw_addi_ready", in_ready, 1);
    check_eq("raw_rs1_enc", rs1_enc, 0);
    tick;
    check_eq("raw_addi_valid", out_valid, 1);
    check_eq("raw_addi_op1_x0", out_op1, 0);
    check_eq("raw_addi_rd", out_rd, 5);
    check_eq("raw_addi_rd_we", out_rd_we, 1);
    check_eq("raw_addi_pc", out_pc, 32'h100);
    check_eq("raw_busy5_set", dut.u_sb.busy[5], 1);
    instr = r_type(5'd6, 5'd5, 5'd5); pc_in = 32'h104; rs1 = 32'h55; rs2 = 32'h66;
    #1;
    check_eq("raw_stall_ready_c1", in_ready, 0);
    tick;
    check_eq("raw_stall_ready_c2", in_ready, 0);
    check_eq("raw_drained", out_valid, 0);
    wb_valid = 1'b1; wb_enc = 5'd5; wb_data = 32'd7;
    #1;
    check_eq("raw_wb_ready", in_ready, 1);
    tick;
    wb_valid = 1'b0; in_valid = 1'b0;
    check_eq("raw_op1_bypass", out_op1, 7);
    check_eq("raw_op2_bypass", out_op2, 7);
    check_eq("raw_add_rd", out_rd, 6);
    check_eq("raw_add_pc", out_pc, 32'h104);
    check_eq("raw_busy5_clr", dut.u_sb.busy[5], 0);
    check_eq("raw_busy6_set", dut.u_sb.busy[6], 1);

    // Backpressure: hold add x6 for 3 cycles while addi x8 waits
    out_ready = 1'b0; instr = i_type(5'd8, 5'd0, 12'd3); pc_in = 32'h108; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("bp_ready", in_ready, 0);
      tick;
      check_eq("bp_valid", out_valid, 1);
      check_eq("bp_instr_hold", out_instr, r_type(5'd6, 5'd5, 5'd5));
      check_eq("bp_op1_hold", out_op1, 7);
      check_eq("bp_pc_hold", out_pc, 32'h104);
    end
    out_ready = 1'b1;
    #1;
    check_eq("bp_release_ready", in_ready, 1);
    tick;
    check_eq("bp_new_instr", out_instr, i_type(5'd8, 5'd0, 12'd3));
    check_eq("bp_new_pc", out_pc, 32'h108);
    check_eq("bp_new_valid", out_valid, 1);
    check_eq("bp_busy8", dut.u_sb.busy[8], 1);
    in_valid = 1'b0; wb_valid = 1'b1; wb_enc = 5'd6; wb_data = 32'h0;
    tick;
    wb_enc = 5'd8;
    tick;
    wb_valid = 1'b0;
    check_eq("bp_busy_clean", dut.u_sb.busy, 0);
    check_eq("bp_drained", out_valid, 0);

    // x0: add x0,x1,x2 then add x3,x0,x0
    instr = r_type(5'd0, 5'd1, 5'd2); pc_in = 32'h200; rs1 = 32'h11; rs2 = 32'h22;
    in_valid = 1'b1;
    #1;
    check_eq("x0_first_ready", in_ready, 1);
    tick;
    check_eq("x0_first_rd_we", out_rd_we, 0);
    check_eq("x0_first_op1", out_op1, 32'h11);
    check_eq("x0_first_op2", out_op2, 32'h22);
    check_eq("x0_busy_none", dut.u_sb.busy, 0);
    instr = r_type(5'd3, 5'd0, 5'd0); pc_in = 32'h204;
    #1;
    check_eq("x0_second_ready", in_ready, 1);
    tick;
    check_eq("x0_second_op1", out_op1, 0);
    check_eq("x0_second_op2", out_op2, 0);
    check_eq("x0_second_rd_we", out_rd_we, 1);
    check_eq("x0_second_rd", out_rd, 3);

    // WAW: busy[7] set, then addi x7 accepted in the same cycle as wb to x7
    instr = i_type(5'd7, 5'd0, 12'd1); pc_in = 32'h208;
    wb_valid = 1'b1; wb_enc = 5'd3;
    tick;
    check_eq("waw_busy7_first", dut.u_sb.busy[7], 1);
    check_eq("waw_busy3_clr", dut.u_sb.busy[3], 0);
    instr = i_type(5'd7, 5'd0, 12'd2); pc_in = 32'h20c; wb_enc = 5'd7;
    #1;
    check_eq("waw_ready", in_ready, 1);
    tick;
    check_eq("waw_busy7_kept", dut.u_sb.busy[7], 1);
    check_eq("waw_instr", out_instr, i_type(5'd7, 5'd0, 12'd2));

    // Flush: issue addi x9 (retiring x7), then flush it
    instr = i_type(5'd9, 5'd0, 12'd5); pc_in = 32'h300;
    tick;
    check_eq("fl_rd9", out_rd, 9);
    check_eq("fl_busy9_set", dut.u_sb.busy[9], 1);
    check_eq("fl_busy7_clr", dut.u_sb.busy[7], 0);
    wb_valid = 1'b0; flush = 1'b1; out_ready = 1'b0;
    instr = i_type(5'd11, 5'd0, 12'd1); pc_in = 32'h304;
    #1;
    check_eq("fl_ready", in_ready, 0);
    tick;
    flush = 1'b0;
    check_eq("fl_valid", out_valid, 0);
    check_eq("fl_busy9_clr", dut.u_sb.busy[9], 0);
    check_eq("fl_no_accept_pc", out_pc, 32'h300);
    check_eq("fl_busy_all", dut.u_sb.busy, 0);

    // Flush and write-back to the same register in one cycle
    out_ready = 1'b1; instr = i_type(5'd10, 5'd0, 12'd1); pc_in = 32'h308;
    tick;
    in_valid = 1'b0; flush = 1'b1; wb_valid = 1'b1; wb_enc = 5'd10;
    tick;
    flush = 1'b0; wb_valid = 1'b0;
    check_eq("flwb_busy", dut.u_sb.busy, 0);
    check_eq("flwb_valid", out_valid, 0);

    // Asynchronous reset mid-transfer
    out_ready = 1'b0; instr = i_type(5'd12, 5'd0, 12'd4); pc_in = 32'h400; in_valid = 1'b1;
    tick;
    check_eq("ar_pre_valid", out_valid, 1);
    check_eq("ar_pre_busy12", dut.u_sb.busy[12], 1);
    rst = 1'b0;
    #1;
    check_eq("ar_valid", out_valid, 0);
    check_eq("ar_busy", dut.u_sb.busy, 0);
    check_eq("ar_pc", out_pc, 0);
    check_eq("ar_instr", out_instr, 0);
    rst = 1'b1; in_valid = 1'b0;
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
